// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: game states, BCD score word,
// and a small helper that turns a 0..99 constant into a BCD increment.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } game_st_t;

  typedef logic [15:0] bcd4_t;

  localparam bcd4_t BCD_MAX = 16'h9999;
  localparam bcd4_t BCD_ONE = 16'h0001;

  function automatic bcd4_t small_to_bcd(input logic [7:0] v);
    return {8'h00, 4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

endpackage

// File: rtl/bcd4_sat_add.sv
// Combinational 4-digit BCD adder; a carry out of the top digit clamps the
// result to 9999 instead of wrapping.
module bcd4_sat_add
  import score_pkg::*;
(
  input  bcd4_t a_i,
  input  bcd4_t b_i,
  output bcd4_t sum_o
);

  logic [4:0] dsum;
  logic       carry;
  bcd4_t      raw;

  always_comb begin
    dsum  = '0;
    carry = 1'b0;
    raw   = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0000, carry};
      // Digit sums above 9 skip the six unused codes and carry into the next digit.
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[4*i +: 4] = dsum[3:0];
    end
    sum_o = carry ? BCD_MAX : raw;
  end

endmodule

// File: rtl/score_keeper.sv
// Game score/round/lives bookkeeping with IDLE/PLAY/PAUSE/OVER sequencing.
// Optional feature macro: COMBO_BONUS_EN (doubles hit points from the 4th straight hit).
module score_keeper
  import score_pkg::*;
#(
  parameter int PTS_PER_HIT    = 1,
  parameter int HITS_PER_ROUND = 10,
  parameter int LIVES          = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  input  logic        pause,
  output logic [15:0] pts,
  output logic [15:0] hpts,
  output logic [15:0] rounds,
  output logic [3:0]  lives,
  output logic [1:0]  game_st,
  output logic        new_high
);

  localparam bcd4_t      HIT_INC    = small_to_bcd(8'(PTS_PER_HIT));
  localparam logic [7:0] HIT_LAST   = 8'(HITS_PER_ROUND - 1);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);

  game_st_t   state_q, state_d;
  bcd4_t      pts_q, pts_d, hpts_q, hpts_d, rounds_q, rounds_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic       new_high_q, new_high_d;
  logic       check_high_q, check_high_d;
  bcd4_t      pts_inc, pts_sum, rounds_sum;

`ifdef COMBO_BONUS_EN
  localparam bcd4_t BONUS_INC = small_to_bcd(8'(2 * PTS_PER_HIT));
  logic [3:0] streak_q, streak_d;
  assign pts_inc = (streak_q >= 4'd3) ? BONUS_INC : HIT_INC;
`else
  assign pts_inc = HIT_INC;
`endif

  bcd4_sat_add u_pts_add    (.a_i(pts_q),    .b_i(pts_inc), .sum_o(pts_sum));
  bcd4_sat_add u_rounds_add (.a_i(rounds_q), .b_i(BCD_ONE), .sum_o(rounds_sum));

  always_comb begin
    state_d      = state_q;
    pts_d        = pts_q;
    hpts_d       = hpts_q;
    rounds_d     = rounds_q;
    lives_d      = lives_q;
    hit_cnt_d    = hit_cnt_q;
    new_high_d   = 1'b0;
    check_high_d = 1'b0;
`ifdef COMBO_BONUS_EN
    streak_d     = streak_q;
`endif
    // The high-score compare runs one cycle after OVER entry, on the final score.
    if (check_high_q && (pts_q > hpts_q)) begin
      hpts_d     = pts_q;
      new_high_d = 1'b1;
    end
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = PLAY;
          pts_d     = '0;
          rounds_d  = BCD_ONE;
          lives_d   = LIVES_INIT;
          hit_cnt_d = '0;
`ifdef COMBO_BONUS_EN
          streak_d  = '0;
`endif
        end
      end
      PLAY: begin
        if (pause) begin
          state_d = PAUSE;
        end else begin
          if (hit) begin
            pts_d = pts_sum;
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d = '0;
              rounds_d  = rounds_sum;
            end else begin
              hit_cnt_d = hit_cnt_q + 8'd1;
            end
`ifdef COMBO_BONUS_EN
            if (streak_q != 4'd15) streak_d = streak_q + 4'd1;
`endif
          end
          if (miss) begin
            lives_d = lives_q - 4'd1;
`ifdef COMBO_BONUS_EN
            streak_d = '0;
`endif
            if (lives_q == 4'd1) begin
              state_d      = OVER;
              check_high_d = 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (!pause) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pts_q        <= '0;
      hpts_q       <= '0;
      rounds_q     <= '0;
      lives_q      <= '0;
      hit_cnt_q    <= '0;
      new_high_q   <= 1'b0;
      check_high_q <= 1'b0;
`ifdef COMBO_BONUS_EN
      streak_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pts_q        <= pts_d;
      hpts_q       <= hpts_d;
      rounds_q     <= rounds_d;
      lives_q      <= lives_d;
      hit_cnt_q    <= hit_cnt_d;
      new_high_q   <= new_high_d;
      check_high_q <= check_high_d;
`ifdef COMBO_BONUS_EN
      streak_q     <= streak_d;
`endif
    end
  end

  assign pts      = pts_q;
  assign hpts     = hpts_q;
  assign rounds   = rounds_q;
  assign lives    = lives_q;
  assign game_st  = state_q;
  assign new_high = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: cycle-by-cycle scoreboard against a
// behavioural model, plus directed checks at the game's key points.
module tb_score_keeper;

  logic        clk, rst, start, hit, miss, pause;
  logic [15:0] pts, hpts, rounds;
  logic [3:0]  lives;
  logic [1:0]  game_st;
  logic        new_high;

  int checks   = 0;
  int failures = 0;

  logic [54:0] exp_q[$];

  // Model state, binary integers.
  int m_st = 0, m_pts = 0, m_hpts = 0, m_rounds = 0, m_lives = 0;
  int m_hc = 0, m_nh = 0, m_chk = 0, m_streak = 0;

  score_keeper dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss), .pause(pause),
    .pts(pts), .hpts(hpts), .rounds(rounds), .lives(lives),
    .game_st(game_st), .new_high(new_high)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int min9999(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic h, input logic m, input logic p,
                            input logic r);
    int inc;
    if (!r) begin
      m_st = 0; m_pts = 0; m_hpts = 0; m_rounds = 0; m_lives = 0;
      m_hc = 0; m_nh = 0; m_chk = 0; m_streak = 0;
      return;
    end
    m_nh = 0;
    if (m_chk != 0 && m_pts > m_hpts) begin
      m_hpts = m_pts;
      m_nh   = 1;
    end
    m_chk = 0;
    case (m_st)
      0, 3: if (s) begin
        m_st = 1; m_pts = 0; m_rounds = 1; m_lives = 3; m_hc = 0; m_streak = 0;
      end
      1: begin
        if (p) m_st = 2;
        else begin
          inc = 1;
`ifdef COMBO_BONUS_EN
          if (m_streak >= 3) inc = 2;
`endif
          if (h) begin
            m_pts = min9999(m_pts + inc);
            m_hc++;
            if (m_hc == 10) begin
              m_hc = 0;
              m_rounds = min9999(m_rounds + 1);
            end
            if (m_streak < 15) m_streak++;
          end
          if (m) begin
            m_lives--;
            m_streak = 0;
            if (m_lives == 0) begin
              m_st  = 3;
              m_chk = 1;
            end
          end
        end
      end
      default: if (!p) m_st = 1;
    endcase
  endtask

  task automatic step(input logic s, input logic h, input logic m, input logic p,
                      input logic r = 1'b1);
    logic [54:0] got, exp;
    start = s; hit = h; miss = m; pause = p; rst = r;
    model_step(s, h, m, p, r);
    exp_q.push_back({2'(m_st), 4'(m_lives), to_bcd(m_rounds), to_bcd(m_hpts),
                     to_bcd(m_pts), 1'(m_nh)});
    @(posedge clk);
    #1;
    got = {game_st, lives, rounds, hpts, pts, new_high};
    exp = exp_q.pop_front();
    check("cycle", 64'(got), 64'(exp));
    start = 1'b0; hit = 1'b0; miss = 1'b0; rst = 1'b1;
  endtask

`ifdef COMBO_BONUS_EN
  localparam logic [15:0] PTS_12_HITS = 16'h0021;
`else
  localparam logic [15:0] PTS_12_HITS = 16'h0012;
`endif

  initial begin
    logic p_lvl;
    rst = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0; pause = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_pts", 64'(pts), 64'h0);
    check("rst_hpts", 64'(hpts), 64'h0);
    check("rst_rounds", 64'(rounds), 64'h0);
    check("rst_state", 64'(game_st), 64'h0);
    check("rst_lives", 64'(lives), 64'h0);

    // Start, 12 hits
    step(1, 0, 0, 0);
    check("start_rounds", 64'(rounds), 64'h1);
    check("start_lives", 64'(lives), 64'd3);
    step(1, 0, 0, 0);  // start during PLAY is ignored
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    check("hits12_pts", 64'(pts), 64'(PTS_12_HITS));
    check("hits12_rounds", 64'(rounds), 64'h0002);

    // Three misses end the game; high score latched one cycle later
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("over_state", 64'(game_st), 64'd3);
    check("over_hpts_before", 64'(hpts), 64'h0);
    check("over_nh_before", 64'(new_high), 64'h0);
    step(0, 1, 0, 0);
    check("over_hpts", 64'(hpts), 64'(PTS_12_HITS));
    check("over_nh_pulse", 64'(new_high), 64'h1);
    step(0, 0, 0, 0);
    check("over_nh_clear", 64'(new_high), 64'h0);
    check("over_pts_hold", 64'(pts), 64'(PTS_12_HITS));

    // Pause with hits every cycle
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1);
      check("pause_state", 64'(game_st), 64'd2);
      check("pause_pts", 64'(pts), 64'h0001);
    end
    step(0, 1, 0, 0);
    check("unpause_state", 64'(game_st), 64'd1);
    check("unpause_pts", 64'(pts), 64'h0001);

    // hit+miss on the last life
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check("lastlife_pts", 64'(pts), 64'h0002);
    check("lastlife_state", 64'(game_st), 64'd3);
    step(0, 0, 0, 0);
    check("lastlife_no_high", 64'(new_high), 64'h0);

`ifdef COMBO_BONUS_EN
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    check("combo_pts", 64'(pts), 64'h0007);
`endif

    // Saturation
    step(1, 0, 0, 0);
    for (int i = 0; i < 9998; i++) step(0, 1, 0, 0);
    check("preload_pts", 64'(pts), 64'(to_bcd(m_pts)));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("sat_pts", 64'(pts), 64'h9999);

    // Reset mid-game
    step(0, 1, 1, 0, 0);
    check("midrst_state", 64'(game_st), 64'h0);
    check("midrst_hpts", 64'(hpts), 64'h0);

    // Random traffic
    p_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), p_lvl, 1'(i != 300));
    end

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
